// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter that funnels four requesters' register writes onto one
// shared register-bank write port (one-hot enable plus shared data).
module reg_wr_arbiter #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  localparam int unsigned ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic                  hold,
  output logic [3:0]            grant,
  output logic [NUM_REGS-1:0]   reg_en,
  output logic [DATA_W-1:0]     reg_wdata,
  output logic                  busy,
  output logic [15:0]           wr_count
);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e              state_q, state_d;
  logic [1:0]          last_grant_q, last_grant_d;
  logic [3:0]          grant_d;
  logic [NUM_REGS-1:0] reg_en_d;
  logic [DATA_W-1:0]   reg_wdata_d;
  logic [15:0]         wr_count_d;

  logic [3:0]          req_eligible;
  logic                found;
  logic [1:0]          win;
  logic [1:0]          idx;
  int unsigned         win_u;
  logic [ADDR_W-1:0]   win_addr;

  // The requester being written this cycle is masked out, so it cannot be
  // granted twice before it has had a chance to drop req.
  always_comb begin
    req_eligible = req & ~grant;
    busy         = (|req_eligible) || (state_q == StWrite);
  end

  // Round-robin winner search starting just after the last granted requester.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant_q + 2'(k);
      if (!found && req_eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_u    = 32'(win);
    win_addr = req_addr[win_u*ADDR_W +: ADDR_W];
  end

  // Next-state and registered-output decode; WRITE always lasts one cycle.
  always_comb begin
    state_d      = StIdle;
    last_grant_d = last_grant_q;
    grant_d      = '0;
    reg_en_d     = '0;
    reg_wdata_d  = reg_wdata;
    wr_count_d   = wr_count;
    if (!hold && found) begin
      state_d           = StWrite;
      last_grant_d      = win;
      grant_d[win]      = 1'b1;
      reg_en_d[win_addr] = 1'b1;
      reg_wdata_d       = req_data[win_u*DATA_W +: DATA_W];
      wr_count_d        = (wr_count == 16'hFFFF) ? wr_count : wr_count + 16'd1;
    end
  end

  // State and output registers; reset clears any in-flight write at once.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 2'd3;
      grant        <= '0;
      reg_en       <= '0;
      reg_wdata    <= '0;
      wr_count     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant        <= grant_d;
      reg_en       <= reg_en_d;
      reg_wdata    <= reg_wdata_d;
      wr_count     <= wr_count_d;
    end
  end

endmodule
